// File: rtl/cpu_stage_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_stage_sequencer
//
// Purpose:
//   Multi-cycle control unit for the 5-stage CPU core. It walks each
//   instruction through FETCH, DECODE (operand read), EXEC, MEM and WB, one
//   cycle per stage. In each stage it raises exactly one registered,
//   one-hot enable for the datapath. It also owns the program counter,
//   resolves JMP/JLZ, and provides run/step/halt control.
//
// Ports:
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous, active-high; overrides every other input
//   run         in   level: 1 = free-run, 0 = stop after current instruction
//   step        in   1-cycle pulse: from IDLE, execute exactly one instruction
//   cop         in   opcode from instruction register (valid from DECODE on)
//   jmp_target  in   branch target field from instruction register
//   lz          in   less-than-zero flag from datapath (sampled in WB)
//   pc          out  program counter / command-memory address
//   stage       out  0..4 = current stage, 7 = IDLE or HALTED
//   fetch_en    out  load instruction register      (stage 0)
//   read_en     out  latch operands into alu1/alu2  (stage 1)
//   exec_en     out  update result register and lz  (stage 2)
//   mem_en      out  memory-indirect register write (stage 3)
//   wb_en       out  register/memory writeback      (stage 4)
//   busy        out  1 while an instruction is in flight
//   halted      out  1 after a HALT opcode retires
//   retired     out  saturating retired-instruction count
// -----------------------------------------------------------------------------
module cpu_stage_sequencer #(
  parameter int CMD_ADDR_WIDTH = 6,
  parameter int COP_WIDTH      = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      step,
  input  logic [COP_WIDTH-1:0]      cop,
  input  logic [CMD_ADDR_WIDTH-1:0] jmp_target,
  input  logic                      lz,
  output logic [CMD_ADDR_WIDTH-1:0] pc,
  output logic [2:0]                stage,
  output logic                      fetch_en,
  output logic                      read_en,
  output logic                      exec_en,
  output logic                      mem_en,
  output logic                      wb_en,
  output logic                      busy,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [COP_WIDTH-1:0] OP_JLZ  = COP_WIDTH'(5);
  localparam logic [COP_WIDTH-1:0] OP_JMP  = COP_WIDTH'(8);
  localparam logic [COP_WIDTH-1:0] OP_HALT = COP_WIDTH'(15);

  state_t                      state_q, state_d;
  logic [CMD_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [COP_WIDTH-1:0]        cop_q, cop_d;
  logic                        step_mode_q, step_mode_d;
  logic [2:0]                  stage_q, stage_d;
  logic                        fetch_en_q, fetch_en_d;
  logic                        read_en_q, read_en_d;
  logic                        exec_en_q, exec_en_d;
  logic                        mem_en_q, mem_en_d;
  logic                        wb_en_q, wb_en_d;
  logic                        busy_q, busy_d;
  logic                        halted_q, halted_d;
  logic [CNT_WIDTH-1:0]        retired_q, retired_d;

  // Next-state logic. The opcode is captured in DECODE so that the WB
  // decision (branch, halt) does not depend on cop staying put afterwards.
  // step_mode remembers that the current instruction was launched by a
  // step pulse, so it returns to IDLE even if run rises mid-instruction.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cop_d       = cop_q;
    step_mode_d = step_mode_q;
    retired_d   = retired_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXEC;
        cop_d   = cop;
      end
      S_EXEC:   state_d = S_MEM;
      S_MEM:    state_d = S_WB;
      S_WB: begin
        if (retired_q != {CNT_WIDTH{1'b1}}) begin
          retired_d = retired_q + CNT_WIDTH'(1);
        end
        if (cop_q == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          if (cop_q == OP_JMP || (cop_q == OP_JLZ && lz)) begin
            pc_d = jmp_target;
          end else begin
            pc_d = pc_q + CMD_ADDR_WIDTH'(1);
          end
          state_d = (run && !step_mode_q) ? S_FETCH : S_IDLE;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every status output is a flop
  // that lines up cycle-for-cycle with the state register.
  always_comb begin
    fetch_en_d = (state_d == S_FETCH);
    read_en_d  = (state_d == S_DECODE);
    exec_en_d  = (state_d == S_EXEC);
    mem_en_d   = (state_d == S_MEM);
    wb_en_d    = (state_d == S_WB);
    busy_d     = fetch_en_d | read_en_d | exec_en_d | mem_en_d | wb_en_d;
    halted_d   = (state_d == S_HALTED);
    case (state_d)
      S_FETCH:  stage_d = 3'd0;
      S_DECODE: stage_d = 3'd1;
      S_EXEC:   stage_d = 3'd2;
      S_MEM:    stage_d = 3'd3;
      S_WB:     stage_d = 3'd4;
      default:  stage_d = 3'd7;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cop_q       <= '0;
      step_mode_q <= 1'b0;
      stage_q     <= 3'd7;
      fetch_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      exec_en_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      wb_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cop_q       <= cop_d;
      step_mode_q <= step_mode_d;
      stage_q     <= stage_d;
      fetch_en_q  <= fetch_en_d;
      read_en_q   <= read_en_d;
      exec_en_q   <= exec_en_d;
      mem_en_q    <= mem_en_d;
      wb_en_q     <= wb_en_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign pc       = pc_q;
  assign stage    = stage_q;
  assign fetch_en = fetch_en_q;
  assign read_en  = read_en_q;
  assign exec_en  = exec_en_q;
  assign mem_en   = mem_en_q;
  assign wb_en    = wb_en_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule
